pc_seq_ctrl: RTL and testbench

//  Fetch/PC sequencer for the single-issue npc core. Owns the architectural PC register.

---
 rtl/pc_seq_ctrl_pkg.sv | 23 ++
 rtl/pc_seq_wdt.sv | 26 ++
 rtl/pc_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_pc_seq_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_ctrl_pkg.sv
// Shared npc definitions: FSM state encodings, reset PC default and instruction width.
package pc_seq_ctrl_pkg;

    localparam logic [2:0] S_REQ   = 3'd0;
    localparam logic [2:0] S_RESP  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    typedef enum logic [2:0] {
        ST_REQ   = S_REQ,
        ST_RESP  = S_RESP,
        ST_ISSUE = S_ISSUE,
        ST_EXEC  = S_EXEC,
        ST_HALT  = S_HALT,
        ST_ERR   = S_ERR
    } state_t;

    localparam logic [31:0] NPC_RESET_PC = 32'h8000_0000;
    localparam int          INST_W       = 32;

endpackage

// File: rtl/pc_seq_wdt.sv
// Fetch watchdog: clearable saturating up-counter whose terminal-count output flags
// that the final allowed cycle (or later) has been reached.
module pc_seq_wdt #(
    parameter int           W  = 16,
    parameter logic [W-1:0] TC = '1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt_q <= '0;
        else if (inc && (cnt_q != '1))
            cnt_q <= cnt_q + 1'b1;
    end

    // >= keeps the timeout armed if a last-cycle request handshake carries us into RESP
    assign tc = (cnt_q >= TC);

endmodule

// File: rtl/pc_seq_ctrl.sv
// Fetch/PC sequencer for the npc core: owns the PC, fetches, issues to decode, retires on commit.
// Optional PC_ALIGN_CHK_EN: a commit to a misaligned target sends the controller to ERR.
module pc_seq_ctrl
    import pc_seq_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = NPC_RESET_PC,
    parameter logic [15:0] TIMEOUT_CYC = 16'd1024,
    parameter int          CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic [31:0]       pc,
    output logic              ifu_req_valid,
    input  logic              ifu_req_ready,
    output logic [31:0]       ifu_req_addr,
    input  logic              ifu_rsp_valid,
    output logic              ifu_rsp_ready,
    input  logic [INST_W-1:0] ifu_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    input  logic              commit,
    input  logic [31:0]       pc_next,
    input  logic              halt_req,
    output logic              halted,
    output logic              err,
    output logic              err_misalign,
    output logic [CNT_W-1:0]  retired_cnt
);

    state_t            state_q, state_d;
    logic [31:0]       pc_q;
    logic [INST_W-1:0] inst_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              wdt_tc;
    logic              fetching;
    logic              retire;
    logic              pc_load;
    logic              misalign;
    logic              run;

    assign run      = !rst;
    assign fetching = (state_q == ST_REQ) || (state_q == ST_RESP);

    // Clearing whenever we are outside REQ/RESP means the count is zero on every REQ entry
    pc_seq_wdt #(
        .W  (16),
        .TC (TIMEOUT_CYC - 16'd1)
    ) u_wdt (
        .clk (clk),
        .rst (rst),
        .clr (!fetching),
        .inc (fetching),
        .tc  (wdt_tc)
    );

`ifdef PC_ALIGN_CHK_EN
    assign misalign = (pc_next[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        pc_load = 1'b0;
        case (state_q)
            ST_REQ: begin
                if (ifu_req_ready)
                    state_d = ST_RESP;
                else if (wdt_tc)
                    state_d = ST_ERR;
            end
            ST_RESP: begin
                if (ifu_rsp_valid)
                    state_d = ST_ISSUE;
                else if (wdt_tc)
                    state_d = ST_ERR;
            end
            ST_ISSUE: begin
                if (inst_ready)
                    state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (commit) begin
                    retire = 1'b1;
                    if (misalign) begin
                        state_d = ST_ERR;
                    end else begin
                        pc_load = 1'b1;
                        state_d = halt_req ? ST_HALT : ST_REQ;
                    end
                end
            end
            ST_HALT: state_d = ST_HALT;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (pc_load)
                pc_q <= pc_next;
            if ((state_q == ST_RESP) && ifu_rsp_valid)
                inst_q <= ifu_rsp_data;
            if (retire)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

`ifdef PC_ALIGN_CHK_EN
    logic misalign_q;

    always_ff @(posedge clk) begin
        if (rst)
            misalign_q <= 1'b0;
        else if ((state_q == ST_EXEC) && commit && misalign)
            misalign_q <= 1'b1;
    end

    assign err_misalign = run && misalign_q;
`else
    assign err_misalign = 1'b0;
`endif

    // Handshake outputs are held low while rst is high so an in-flight transfer aborts at once
    assign ifu_req_valid = run && (state_q == ST_REQ);
    assign ifu_rsp_ready = run && (state_q == ST_RESP);
    assign inst_valid    = run && (state_q == ST_ISSUE);
    assign halted        = run && (state_q == ST_HALT);
    assign err           = run && (state_q == ST_ERR);

    assign pc           = pc_q;
    assign ifu_req_addr = pc_q;
    assign inst         = inst_q;
    assign retired_cnt  = cnt_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed bench for pc_seq_ctrl: table-driven fetch loop plus hand-written corner sequences.
module tb_pc_seq_ctrl;

    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_ready, ifu_rsp_valid, inst_ready, commit, halt_req;
    logic [31:0] ifu_rsp_data, pc_next;

    logic [31:0] pc, ifu_req_addr, inst, retired_cnt;
    logic        ifu_req_valid, ifu_rsp_ready, inst_valid, halted, err, err_misalign;

    logic [31:0] pc_t, ifu_req_addr_t, inst_t, retired_cnt_t;
    logic        ifu_req_valid_t, ifu_rsp_ready_t, inst_valid_t, halted_t, err_t, err_misalign_t;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pc_seq_ctrl dut (
        .clk(clk), .rst(rst), .pc(pc),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_data(ifu_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .commit(commit), .pc_next(pc_next), .halt_req(halt_req),
        .halted(halted), .err(err), .err_misalign(err_misalign), .retired_cnt(retired_cnt)
    );

    pc_seq_ctrl #(.TIMEOUT_CYC(16'd8)) dut_t (
        .clk(clk), .rst(rst), .pc(pc_t),
        .ifu_req_valid(ifu_req_valid_t), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr_t),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready_t), .ifu_rsp_data(ifu_rsp_data),
        .inst_valid(inst_valid_t), .inst_ready(inst_ready), .inst(inst_t),
        .commit(commit), .pc_next(pc_next), .halt_req(halt_req),
        .halted(halted_t), .err(err_t), .err_misalign(err_misalign_t), .retired_cnt(retired_cnt_t)
    );

    typedef struct {
        logic        req_ready;
        logic        rsp_valid;
        logic [31:0] rsp_data;
        logic        inst_ready;
        logic        commit;
        logic [31:0] pc_next;
        logic        exp_req_valid;
        logic        exp_rsp_ready;
        logic        exp_inst_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        ifu_rsp_data  = '0;
        inst_ready    = 1'b0;
        commit        = 1'b0;
        pc_next       = '0;
        halt_req      = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        step();
        step();
        rst = 1'b0;
    endtask

    // Zero-wait fetch of one word, leaving the DUT in EXEC
    task automatic fetch_to_exec(input logic [31:0] data);
        ifu_req_ready = 1'b1; step(); ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b1; ifu_rsp_data = data; step(); ifu_rsp_valid = 1'b0;
        inst_ready = 1'b1; step(); inst_ready = 1'b0;
    endtask

    function automatic vec_t mk(input logic rr, input logic rv, input logic [31:0] rd,
                                input logic ir, input logic cm, input logic [31:0] pn,
                                input logic erq, input logic ers, input logic eiv,
                                input logic [31:0] epc, input logic [31:0] ein,
                                input logic [31:0] ecnt);
        vec_t v;
        v.req_ready = rr; v.rsp_valid = rv; v.rsp_data = rd; v.inst_ready = ir;
        v.commit = cm; v.pc_next = pn;
        v.exp_req_valid = erq; v.exp_rsp_ready = ers; v.exp_inst_valid = eiv;
        v.exp_pc = epc; v.exp_inst = ein; v.exp_cnt = ecnt;
        return v;
    endfunction

    initial begin
        logic [31:0] p;
        logic [31:0] w;

        // Reset state
        rst = 1'b1;
        idle();
        step();
        chk("rst_pc", pc, RPC);
        chk("rst_inst", inst, 32'h0);
        chk("rst_cnt", retired_cnt, 32'h0);
        chk("rst_req_valid", {31'h0, ifu_req_valid}, 32'h0);
        chk("rst_flags", {ifu_rsp_ready, inst_valid, halted, err, err_misalign}, 32'h0);
        rst = 1'b0;
        #1;
        chk("req_after_rst", {ifu_req_valid, ifu_rsp_ready}, 32'h2);
        chk("req_addr0", ifu_req_addr, RPC);

        // Three back-to-back zero-wait instructions, pc_next = pc + 4
        for (int k = 0; k < 3; k++) begin
            p = RPC + 32'(4 * k);
            w = 32'h0000_0013 + 32'(k << 20);
            vecs.push_back(mk(1, 0, 0, 0, 0, 0,         0, 1, 0, p,      32'(k == 0 ? 0 : w - 32'h0010_0000), 32'(k)));
            vecs.push_back(mk(0, 1, w, 0, 0, 0,         0, 0, 1, p,      w, 32'(k)));
            vecs.push_back(mk(0, 0, 0, 1, 0, 0,         0, 0, 0, p,      w, 32'(k)));
            vecs.push_back(mk(0, 0, 0, 0, 1, p + 32'd4, 1, 0, 0, p + 4,  w, 32'(k + 1)));
        end
        foreach (vecs[i]) begin
            ifu_req_ready = vecs[i].req_ready;
            ifu_rsp_valid = vecs[i].rsp_valid;
            ifu_rsp_data  = vecs[i].rsp_data;
            inst_ready    = vecs[i].inst_ready;
            commit        = vecs[i].commit;
            pc_next       = vecs[i].pc_next;
            step();
            chk($sformatf("v%0d_req_valid", i), {31'h0, ifu_req_valid}, {31'h0, vecs[i].exp_req_valid});
            chk($sformatf("v%0d_rsp_ready", i), {31'h0, ifu_rsp_ready}, {31'h0, vecs[i].exp_rsp_ready});
            chk($sformatf("v%0d_inst_valid", i), {31'h0, inst_valid}, {31'h0, vecs[i].exp_inst_valid});
            chk($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
            chk($sformatf("v%0d_addr", i), ifu_req_addr, vecs[i].exp_pc);
            chk($sformatf("v%0d_inst", i), inst, vecs[i].exp_inst);
            chk($sformatf("v%0d_cnt", i), retired_cnt, vecs[i].exp_cnt);
        end
        idle();
        chk("seq_pc_final", pc, 32'h8000_000C);
        chk("seq_cnt_final", retired_cnt, 32'd3);

        // Memory wait states: request stalls 5 cycles, response 3 cycles
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("wait_req_valid", {31'h0, ifu_req_valid}, 32'h1);
            chk("wait_req_addr", ifu_req_addr, RPC);
        end
        ifu_req_ready = 1'b1; step(); ifu_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("wait_no_dup_req", {31'h0, ifu_req_valid}, 32'h0);
            chk("wait_rsp_ready", {31'h0, ifu_rsp_ready}, 32'h1);
            step();
        end
        ifu_rsp_valid = 1'b1; ifu_rsp_data = 32'h0000_0013; step();
        ifu_rsp_valid = 1'b1; ifu_rsp_data = 32'hDEAD_BEEF;
        chk("wait_inst", inst, 32'h0000_0013);
        chk("wait_inst_valid", {31'h0, inst_valid}, 32'h1);

        // Decode back-pressure; commit and late responses outside their states are ignored
        commit = 1'b1; pc_next = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_inst_valid", {31'h0, inst_valid}, 32'h1);
            chk("stall_inst", inst, 32'h0000_0013);
            chk("stall_pc", pc, RPC);
            chk("stall_cnt", retired_cnt, 32'h0);
        end
        idle();
        inst_ready = 1'b1; step(); inst_ready = 1'b0;
        chk("exec_inst_valid", {31'h0, inst_valid}, 32'h0);

        // Halt on ebreak, then absorbing
        commit = 1'b1; halt_req = 1'b1; pc_next = 32'h8000_0100; step();
        chk("halt_halted", {31'h0, halted}, 32'h1);
        chk("halt_pc", pc, 32'h8000_0100);
        chk("halt_cnt", retired_cnt, 32'h1);
        halt_req = 1'b0; pc_next = 32'h8000_0200; ifu_req_ready = 1'b1;
        step(); step();
        chk("halt_hold", {31'h0, halted}, 32'h1);
        chk("halt_pc_hold", pc, 32'h8000_0100);
        chk("halt_cnt_hold", retired_cnt, 32'h1);
        chk("halt_no_req", {31'h0, ifu_req_valid}, 32'h0);
        do_reset();
        chk("halt_rst_pc", pc, RPC);
        chk("halt_rst_flag", {31'h0, halted}, 32'h0);

        // Watchdog (TIMEOUT_CYC=8): request never accepted
        for (int i = 1; i <= 8; i++) begin
            step();
            chk($sformatf("wdt_err_c%0d", i), {31'h0, err_t}, (i == 8) ? 32'h1 : 32'h0);
        end
        ifu_req_ready = 1'b1; step(); ifu_req_ready = 1'b0;
        chk("wdt_err_absorb", {31'h0, err_t}, 32'h1);
        chk("wdt_err_no_req", {31'h0, ifu_req_valid_t}, 32'h0);

        // Watchdog: accept on the final allowed cycle wins
        do_reset();
        for (int i = 1; i <= 7; i++) step();
        chk("wdt_edge_pre", {31'h0, err_t}, 32'h0);
        ifu_req_ready = 1'b1; step(); ifu_req_ready = 1'b0;
        chk("wdt_edge_err", {31'h0, err_t}, 32'h0);
        chk("wdt_edge_resp", {31'h0, ifu_rsp_ready_t}, 32'h1);

        // Misaligned commit target
        do_reset();
        fetch_to_exec(32'h0000_0013);
        commit = 1'b1; pc_next = 32'h8000_0102; halt_req = 1'b1; step(); idle();
`ifdef PC_ALIGN_CHK_EN
        chk("mis_err", {31'h0, err}, 32'h1);
        chk("mis_flag", {31'h0, err_misalign}, 32'h1);
        chk("mis_pc", pc, RPC);
        chk("mis_halted", {31'h0, halted}, 32'h0);
`else
        do_reset();
        fetch_to_exec(32'h0000_0013);
        commit = 1'b1; pc_next = 32'h8000_0102; step(); idle();
        chk("mis_err", {31'h0, err}, 32'h0);
        chk("mis_flag", {31'h0, err_misalign}, 32'h0);
        chk("mis_pc", pc, 32'h8000_0102);
        chk("mis_next_req", {31'h0, ifu_req_valid}, 32'h1);
        chk("mis_next_addr", ifu_req_addr, 32'h8000_0102);
`endif
        chk("mis_cnt", retired_cnt, 32'h1);

        // Reset mid-response aborts the fetch and drops the response
        do_reset();
        ifu_req_ready = 1'b1; step(); ifu_req_ready = 1'b0;
        rst = 1'b1; #1;
        chk("abort_rsp_ready", {31'h0, ifu_rsp_ready}, 32'h0);
        ifu_rsp_valid = 1'b1; ifu_rsp_data = 32'hCAFE_F00D; step();
        rst = 1'b0; idle(); #1;
        chk("abort_inst", inst, 32'h0);
        chk("abort_req", {ifu_req_valid, ifu_rsp_ready, inst_valid}, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
